// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared rounding-mode type and LFSR constants for the stochastic rounding pipe
package sr_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SR_TRUNC   = 2'b00,
    SR_NEAREST = 2'b01,
    SR_STOCH   = 2'b10
  } sr_mode_e;

  // Right-shifting Galois step: feedback from bit 0 folds into the tap positions
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sr_lfsr.sv
// rtl/sr_lfsr.sv - 16-bit Galois LFSR with synchronous seed load and step enable
module sr_lfsr
  import sr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              load,
  input  logic              enable,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (load) begin
      state <= SEED;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/stochastic_round_pipe.sv
// rtl/stochastic_round_pipe.sv - 2-stage round/saturate pipe; macro SR_SAT_COUNT_EN enables the sat_cnt counter
module stochastic_round_pipe
  import sr_pkg::*;
#(
  parameter int                IN_W     = 16,
  parameter int                IN_FRAC  = 8,
  parameter int                OUT_W    = 8,
  parameter int                OUT_FRAC = 0,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      sat_cnt
);

  localparam int D  = IN_FRAC - OUT_FRAC;
  // One guard bit beyond the widest operand so operand + addend never wraps
  localparam int SW = ((IN_W > D) ? IN_W : D) + 2;
  localparam int CW = (SW > OUT_W + 1) ? SW : OUT_W + 1;
  localparam logic signed [CW-1:0] MAX_V = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] MIN_V = ~MAX_V;

  generate
    if (D < 1 || D > 16) begin : g_bad_shift
      $error("stochastic_round_pipe: IN_FRAC-OUT_FRAC must be in 1..16");
    end
    if (SEED == '0) begin : g_bad_seed
      $error("stochastic_round_pipe: SEED must be nonzero");
    end
  endgenerate

  logic              stall;
  logic              accept;
  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_lfsr;

  assign stall       = out_valid & ~out_ready;
  assign in_ready    = ~stall;
  assign accept      = in_valid & in_ready;
  assign unused_lfsr = ^{1'b0, lfsr_q};

  sr_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk   (clk),
    .load  (rst),
    .enable(accept),
    .state (lfsr_q)
  );

  logic        [SW-1:0] addend;
  logic signed [SW-1:0] sum_d;

  always_comb begin
    addend = '0;
    case (sr_mode_e'(in_mode))
      SR_TRUNC: addend = '0;
      SR_STOCH: addend = SW'(lfsr_q[D-1:0]);
      default:  addend = SW'(1) << (D - 1);
    endcase
    sum_d = $signed({{(SW-IN_W){in_data[IN_W-1]}}, in_data} + addend);
  end

  logic                 s1_valid;
  logic signed [SW-1:0] s1_sum;
  logic signed [SW-1:0] shifted;
  logic signed [CW-1:0] wide;
  logic [OUT_W-1:0]     data_d;
  logic                 sat_d;

  always_comb begin
    shifted = s1_sum >>> D;
    wide    = CW'(shifted);
    data_d  = wide[OUT_W-1:0];
    sat_d   = 1'b0;
    if (wide > MAX_V) begin
      data_d = MAX_V[OUT_W-1:0];
      sat_d  = 1'b1;
    end else if (wide < MIN_V) begin
      data_d = MIN_V[OUT_W-1:0];
      sat_d  = 1'b1;
    end
  end

  // Both stages advance together; a stalled output freezes the whole pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= accept;
      if (accept) begin
        s1_sum <= sum_d;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= data_d;
        out_sat  <= sat_d;
      end
    end
  end

`ifdef SR_SAT_COUNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if (out_valid && out_ready && out_sat && sat_cnt_q != 16'hFFFF) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_stochastic_round_pipe.sv
// tb/tb_stochastic_round_pipe.sv - directed-vector and scoreboard bench for stochastic_round_pipe
module tb_stochastic_round_pipe;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sat_cnt;

  stochastic_round_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat_cnt  (sat_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic       s;
  } exp_t;

  exp_t        q_exp[$];
  logic        use_model = 1'b0;
  logic [15:0] lfsr_m = SEED;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_sat;
  int          n1 = 0;
  int          n2 = 0;
  int          sat_seen = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] t;
    t = l >> 1;
    if (l[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  function automatic exp_t ref_round(input logic [15:0] d, input logic [1:0] m, input logic [15:0] l);
    int   x, a, s, q;
    exp_t r;
    x = int'($signed(d));
    if (m == 2'b00) a = 0;
    else if (m == 2'b10) a = int'(l[7:0]);
    else a = 128;
    s = x + a;
    q = s >>> 8;
    if (q > 127) r = '{d: 8'h7F, s: 1'b1};
    else if (q < -128) r = '{d: 8'h80, s: 1'b1};
    else r = '{d: q[7:0], s: 1'b0};
    return r;
  endfunction

  // Scoreboard: sample half a cycle away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q_exp.delete();
      lfsr_m     = SEED;
      prev_stall = 1'b0;
      sat_seen   = 0;
    end else begin
      if (prev_stall) begin
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_sat", 32'(out_sat), 32'(prev_sat));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sat   = out_sat;
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          check("spurious_out", 32'(out_data), 32'hDEAD);
        end else begin
          e = q_exp.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_sat", 32'(out_sat), 32'(e.s));
          if (e.s) sat_seen++;
          if (out_data == 8'h02) n2++;
          else if (out_data == 8'h01) n1++;
        end
      end
      if (in_valid && in_ready) begin
        if (use_model) q_exp.push_back(ref_round(in_data, in_mode, lfsr_m));
        lfsr_m = lfsr_step(lfsr_m);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic vec(input logic [15:0] d, input logic [1:0] m, input logic [7:0] ed, input logic es);
    logic ok;
    ok = 1'b0;
    q_exp.push_back('{d: ed, s: es});
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("vec_accept_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic stream(input int n, input logic rnd, input logic [15:0] d, input logic [1:0] m);
    logic ok;
    for (int b = 0; b < n; b++) begin
      in_valid = 1'b1;
      in_data  = rnd ? 16'($urandom) : d;
      in_mode  = rnd ? 2'($urandom_range(0, 3)) : m;
      ok = 1'b0;
      for (int w = 0; w < 100 && !ok; w++) begin
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
      end
      if (!ok) check("stream_accept_timeout", 32'(ok), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int w = 0; w < 300 && q_exp.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(q_exp.size()), 32'd0);
  endtask

  logic [15:0] vd [11] = '{16'h0140, 16'h0140, 16'h0180, 16'h0180, 16'hFE80, 16'hFE80,
                           16'h7F80, 16'h8000, 16'h0180, 16'h7F7F, 16'h7FFF};
  logic [1:0]  vm [11] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01,
                           2'b01, 2'b00, 2'b11, 2'b01, 2'b00};
  logic [7:0]  ve [11] = '{8'h02, 8'h01, 8'h01, 8'h02, 8'hFE, 8'hFF,
                           8'h7F, 8'h80, 8'h02, 8'h7F, 8'h7F};
  logic        vs [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors, hand-computed for IN_FRAC=8, OUT_W=8
    for (int i = 0; i < 11; i++) vec(vd[i], vm[i], ve[i], vs[i]);
    drain();
`ifdef SR_SAT_COUNT_EN
    check("sat_cnt_directed", 32'(sat_cnt), 32'd1);
`else
    check("sat_cnt_directed", 32'(sat_cnt), 32'd0);
`endif

    // Full LFSR period of stochastic rounding of 1.25
    do_reset();
    use_model = 1'b1;
    n1 = 0;
    n2 = 0;
    stream(65535, 1'b0, 16'h0140, 2'b10);
    drain();
    check("stoch_count_2", 32'(n2), 32'd16384);
    check("stoch_count_1", 32'(n1), 32'd49151);

    // Random data, random modes, random backpressure
    stream(1000, 1'b1, 16'h0000, 2'b00);
    drain();
`ifdef SR_SAT_COUNT_EN
    check("sat_cnt_random", 32'(sat_cnt), 32'(sat_seen));
`else
    check("sat_cnt_random", 32'(sat_cnt), 32'd0);
`endif

    // Reset with both stages full
    out_ready = 1'b0;
    in_data   = 16'h0180;
    in_mode   = 2'b00;
    in_valid  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("full_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    use_model = 1'b0;
    out_ready = 1'b1;
    q_exp.push_back('{d: 8'h02, s: 1'b0});
    in_data  = 16'h0140;
    in_mode  = 2'b10;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_edge2_data", 32'(out_data), 32'h02);
    @(posedge clk);
    #1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
